// File: rtl/adder_op_sequencer_pkg.sv
// rtl/adder_op_sequencer_pkg.sv - shared state encoding and width helper
package adder_op_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Width able to hold 0..depth inclusive (counts, not pointers).
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/adder_op_sequencer_if.sv
// rtl/adder_op_sequencer_if.sv - operand/result streams and adder-side bus
interface adder_op_sequencer_if
  import adder_op_sequencer_pkg::*;
#(
  parameter int N          = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [N-1:0]  adder_a;
  logic [N-1:0]  adder_b;
  logic [N:0]    adder_sum;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    out_sum;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_a, in_b, out_ready, adder_sum,
    input  in_ready, adder_a, adder_b, out_valid, out_sum, busy, count
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready, adder_sum,
    output in_ready, adder_a, adder_b, out_valid, out_sum, busy, count
  );
endinterface

// File: rtl/adder_op_sequencer_sync_fifo.sv
// rtl/adder_op_sequencer_sync_fifo.sv - power-of-2 depth synchronous FIFO, head visible combinationally
module sync_fifo
  import adder_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/adder_op_sequencer.sv
// rtl/adder_op_sequencer.sv - queues operand pairs, issues them one at a time to an external adder,
// and returns the captured sums in order
module adder_op_sequencer
  import adder_op_sequencer_pkg::*;
#(
  parameter int N             = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDER_LATENCY = 1
) (
  input logic                clk,
  input logic                rst_n,
  adder_op_sequencer_if.slave bus
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int LW = (ADDER_LATENCY > 0) ? $clog2(ADDER_LATENCY + 1) : 1;

  state_e          state_q;
  logic [LW-1:0]   lat_q;
  logic [N-1:0]    adder_a_q, adder_b_q;
  logic [N:0]      out_sum_q;
  logic            out_valid_q;

  logic [2*N-1:0]  head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  // in_ready comes from the registered count only, so a pop never unblocks a push in the same cycle.
  assign push = bus.in_valid && !fifo_full;

  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = !fifo_empty;
      HOLD:    pop = bus.out_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH(2 * N),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_a, bus.in_b}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            adder_a_q <= head[2*N-1:N];
            adder_b_q <= head[N-1:0];
            lat_q     <= LW'(ADDER_LATENCY);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            out_sum_q   <= bus.adder_sum;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (pop) begin
              adder_a_q <= head[2*N-1:N];
              adder_b_q <= head[N-1:0];
              lat_q     <= LW'(ADDER_LATENCY);
              state_q   <= WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.adder_a   = adder_a_q;
  assign bus.adder_b   = adder_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.count     = fifo_count;
endmodule
